vector_serializer: RTL and testbench

VECTOR_SERIALIZER -- requirements
Module: vector_serializer

---
 rtl/vector_serializer_pkg.sv | 22 ++
 rtl/vector_serializer.sv | 134 +++++++++++++
 tb/tb_vector_serializer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/vector_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vector_serializer_pkg
// Description : Shared definitions for the vector serializer and the benches
//               of the neighbouring vector reverse stage: FSM state encoding
//               and the default parallel word width.
// Revision    : 1.0 - initial release
// ============================================================================
package vector_serializer_pkg;

    // Default width of one parallel word.
    localparam int DEFAULT_WIDTH = 8;

    // IDLE  : shift register empty, nothing on the serial output.
    // SHIFT : shift register holds a word being emitted bit by bit.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage : vector_serializer_pkg
`default_nettype wire

// File: rtl/vector_serializer.sv
`default_nettype none
// ============================================================================
// Module      : vector_serializer
// Description : Parallel-to-serial converter with one word of look-ahead
//               buffering. A word is accepted on in_valid && in_ready, held in
//               a shift register and presented one bit at a time; each bit is
//               consumed when ser_en is high. A pending register lets the next
//               word be accepted while the current one shifts, so words
//               stream back-to-back without gaps.
// Ports       : clk        - clock, all state updates on the rising edge
//               rst_n      - asynchronous active-low reset
//               in_valid   - upstream word valid
//               in_vector  - parallel word (WIDTH bits)
//               in_ready   - a word can be accepted this cycle
//               ser_en     - downstream consumes the presented bit
//               ser_valid  - ser_data holds a valid bit
//               ser_data   - current serial bit
//               ser_first  - current bit is the first of its word
//               ser_last   - current bit is the last of its word
//               busy       - shift register or pending register occupied
// Revision    : 1.0 - initial release
// ============================================================================
module vector_serializer
    import vector_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_vector,
    output logic             in_ready,
    input  logic             ser_en,
    output logic             ser_valid,
    output logic             ser_data,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   shift_reg;
    logic [WIDTH-1:0]   pend;
    logic               pend_valid;
    logic [CNT_W-1:0]   bit_cnt;

    logic               transfer;
    logic               out_bit;
    logic [WIDTH-1:0]   shift_next;

    // Bit order only changes which end is presented and which way the
    // register moves; the control logic is identical for both orders.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign out_bit    = shift_reg[WIDTH-1];
            assign shift_next = shift_reg << 1;
        end else begin : g_lsb_first
            assign out_bit    = shift_reg[0];
            assign shift_next = shift_reg >> 1;
        end
    endgenerate

    // Readiness depends only on the pending slot. At a word end with the
    // pending slot full, the slot drains into the shift register but is not
    // refilled in the same cycle; the upstream word is taken a cycle later.
    assign in_ready = !pend_valid;
    assign transfer = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        shift_reg <= in_vector;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (ser_en && (bit_cnt == LAST_CNT)) begin
                        // Word end: refill from pending first, otherwise take
                        // a word arriving this cycle straight into the shift
                        // register, otherwise fall back to IDLE.
                        if (pend_valid) begin
                            shift_reg  <= pend;
                            pend       <= '0;
                            pend_valid <= 1'b0;
                            bit_cnt    <= '0;
                        end else if (transfer) begin
                            shift_reg <= in_vector;
                            bit_cnt   <= '0;
                        end else begin
                            shift_reg <= '0;
                            bit_cnt   <= '0;
                            state     <= IDLE;
                        end
                    end else begin
                        if (ser_en) begin
                            shift_reg <= shift_next;
                            bit_cnt   <= bit_cnt + CNT_W'(1);
                        end
                        if (transfer) begin
                            pend       <= in_vector;
                            pend_valid <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ser_valid = (state == SHIFT);
    assign ser_data  = ser_valid && out_bit;
    assign ser_first = ser_valid && (bit_cnt == '0);
    assign ser_last  = ser_valid && (bit_cnt == LAST_CNT);
    assign busy      = (state == SHIFT) || pend_valid;

endmodule : vector_serializer
`default_nettype wire

// File: tb/tb_vector_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_serializer
// Description : Directed self-checking bench for vector_serializer. Two
//               instances share stimulus: one MSB-first, one LSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_serializer;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_vector;
    logic             ser_en;

    logic m_in_ready, m_ser_valid, m_ser_data, m_ser_first, m_ser_last, m_busy;
    logic l_in_ready, l_ser_valid, l_ser_data, l_ser_first, l_ser_last, l_busy;

    int n_checks;
    int n_fail;

    vector_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_vector (in_vector),
        .in_ready  (m_in_ready),
        .ser_en    (ser_en),
        .ser_valid (m_ser_valid),
        .ser_data  (m_ser_data),
        .ser_first (m_ser_first),
        .ser_last  (m_ser_last),
        .busy      (m_busy)
    );

    vector_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_vector (in_vector),
        .in_ready  (l_in_ready),
        .ser_en    (ser_en),
        .ser_valid (l_ser_valid),
        .ser_data  (l_ser_data),
        .ser_first (l_ser_first),
        .ser_last  (l_ser_last),
        .busy      (l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " m_in_ready"},  32'(m_in_ready),  32'd1);
        check({tag, " m_ser_valid"}, 32'(m_ser_valid), 32'd0);
        check({tag, " m_ser_data"},  32'(m_ser_data),  32'd0);
        check({tag, " m_ser_first"}, 32'(m_ser_first), 32'd0);
        check({tag, " m_ser_last"},  32'(m_ser_last),  32'd0);
        check({tag, " m_busy"},      32'(m_busy),      32'd0);
        check({tag, " l_ser_valid"}, 32'(l_ser_valid), 32'd0);
        check({tag, " l_busy"},      32'(l_busy),      32'd0);
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] words [3];
        int         k;
        logic       xfer;

        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vector = '0;
        ser_en    = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // ---------------- single word, both bit orders -------------------
        // Transfer on the first edge after release; ser_en high while idle
        // must have no effect.
        w         = 8'b1101_1010;
        in_valid  = 1'b1;
        in_vector = w;
        ser_en    = 1'b1;
        check("single ready", 32'(m_in_ready), 32'd1);
        tick();
        in_valid  = 1'b0;
        in_vector = 8'h00;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("single m_valid[%0d]", i), 32'(m_ser_valid), 32'd1);
            check($sformatf("single m_data[%0d]", i),  32'(m_ser_data),  32'(w[7-i]));
            check($sformatf("single l_data[%0d]", i),  32'(l_ser_data),  32'(w[i]));
            check($sformatf("single m_first[%0d]", i), 32'(m_ser_first), 32'(i == 0));
            check($sformatf("single m_last[%0d]", i),  32'(m_ser_last),  32'(i == 7));
            check($sformatf("single l_last[%0d]", i),  32'(l_ser_last),  32'(i == 7));
            check($sformatf("single m_busy[%0d]", i),  32'(m_busy),      32'd1);
            tick();
        end
        check("single idle valid", 32'(m_ser_valid), 32'd0);
        check("single idle busy",  32'(m_busy),      32'd0);
        check("single idle data",  32'(m_ser_data),  32'd0);

        // ---------------- back-to-back words ----------------------------
        words[0] = 8'hA5;
        words[1] = 8'h3C;
        words[2] = 8'hFF;
        k         = 0;
        ser_en    = 1'b1;
        in_valid  = 1'b1;
        in_vector = words[0];
        for (int c = 0; c <= 25; c++) begin
            if (c >= 1 && c <= 24) begin
                int b;
                b = c - 1;
                w = words[b / 8];
                check($sformatf("b2b m_valid[%0d]", c), 32'(m_ser_valid), 32'd1);
                check($sformatf("b2b m_data[%0d]", c),  32'(m_ser_data),  32'(w[7 - (b % 8)]));
                check($sformatf("b2b l_data[%0d]", c),  32'(l_ser_data),  32'(w[b % 8]));
                check($sformatf("b2b m_first[%0d]", c), 32'(m_ser_first), 32'((b % 8) == 0));
                check($sformatf("b2b m_ready[%0d]", c), 32'(m_in_ready),
                      32'(!((c >= 2 && c <= 8) || (c >= 10 && c <= 16))));
            end
            if (c == 25) begin
                check("b2b idle valid", 32'(m_ser_valid), 32'd0);
                check("b2b idle busy",  32'(m_busy),      32'd0);
            end
            xfer = in_valid && m_in_ready;
            tick();
            if (xfer) k++;
            in_valid  = (k < 3);
            in_vector = (k < 3) ? words[k] : 8'h00;
        end
        check("b2b words taken", 32'(k), 32'd3);

        // ---------------- ser_en stalls ---------------------------------
        w         = 8'hF0;
        in_valid  = 1'b1;
        in_vector = w;
        ser_en    = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_vector = 8'h00;
        for (int j = 1; j <= 16; j++) begin
            int idx;
            idx    = (j - 1) / 2;
            ser_en = ((j % 2) == 0);
            check($sformatf("stall m_valid[%0d]", j), 32'(m_ser_valid), 32'd1);
            check($sformatf("stall m_data[%0d]", j),  32'(m_ser_data),  32'(w[7 - idx]));
            check($sformatf("stall l_data[%0d]", j),  32'(l_ser_data),  32'(w[idx]));
            check($sformatf("stall m_last[%0d]", j),  32'(m_ser_last),  32'(idx == 7));
            tick();
        end
        ser_en = 1'b0;
        check("stall idle valid", 32'(m_ser_valid), 32'd0);

        // ---------------- reset mid-word --------------------------------
        ser_en    = 1'b1;
        in_valid  = 1'b1;
        in_vector = 8'hA5;
        tick();
        in_vector = 8'h3C;
        tick();
        in_valid  = 1'b0;
        in_vector = 8'h00;
        check("midrst pend full ready", 32'(m_in_ready), 32'd0);
        tick();
        tick();
        check("midrst m_valid before", 32'(m_ser_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst asserted");
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            check_reset_outputs($sformatf("midrst released[%0d]", j));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_vector_serializer
`default_nettype wire
